// File: rtl/tri_dispatch.sv
// tri_dispatch: walks a triangle ROM for one object per frame and hands each
// triangle to the rasterizer with a valid/ready handshake.
// Optional feature: define BACKFACE_CULL_EN to skip back-facing triangles
// (signed area <= 0) during fetch; the last triangle is always issued.
module tri_dispatch #(
  parameter int MAX_TRIS    = 256,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_W      = $clog2(MAX_TRIS)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                new_frame,
  input  logic [ADDR_W:0]     num_tris,
  output logic [ADDR_W-1:0]   tri_addr,
  input  logic [80:0]         tri_data,
  input  logic                ras_ready,
  output logic [2:0][8:0]     vert1,
  output logic [2:0][8:0]     vert2,
  output logic [2:0][8:0]     vert3,
  output logic                valid_tri,
  output logic                obj_done,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_TRIS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_HOLD, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_nlat;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pend;

  logic              w_start, w_last, w_fetch_end, w_cull;
  logic [ADDR_W:0]   w_nclamp;

  assign w_start     = (r_state == S_IDLE) && (new_frame || r_pend);
  assign w_nclamp    = (num_tris > MAX_N) ? MAX_N : num_tris;
  assign w_last      = ({1'b0, r_idx} == (r_nlat - 1'b1));
  assign w_fetch_end = (r_state == S_FETCH) && (r_cnt == CNT_W'(ROM_LATENCY - 1));

`ifdef BACKFACE_CULL_EN
  // Coordinates are unsigned 9-bit; widen to 20-bit signed before differencing.
  logic signed [19:0] w_x1, w_y1, w_x2, w_y2, w_x3, w_y3, w_area;
  assign w_x1   = {11'd0, tri_data[80:72]};
  assign w_y1   = {11'd0, tri_data[71:63]};
  assign w_x2   = {11'd0, tri_data[53:45]};
  assign w_y2   = {11'd0, tri_data[44:36]};
  assign w_x3   = {11'd0, tri_data[26:18]};
  assign w_y3   = {11'd0, tri_data[17:9]};
  assign w_area = (w_x2 - w_x1) * (w_y3 - w_y1) - (w_x3 - w_x1) * (w_y2 - w_y1);
  // Never cull the last triangle so obj_done always reaches the rasterizer.
  assign w_cull = (w_area <= 20'sd0) && !w_last;
`else
  assign w_cull = 1'b0;
`endif

  assign tri_addr   = r_idx;
  assign busy       = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_HOLD);
  assign valid_tri  = (r_state == S_ISSUE) && ras_ready;
  assign obj_done   = valid_tri && w_last;
  assign frame_done = (r_state == S_DONE);
  assign overrun    = new_frame && r_pend && (busy || frame_done);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; HOLD absorbs the rasterizer's one-cycle-late ready drop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (num_tris == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (w_fetch_end) w_next = w_cull ? S_FETCH : S_ISSUE;
      S_ISSUE: if (ras_ready) w_next = S_HOLD;
      S_HOLD:  w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame counters, ROM wait counter and vertex capture.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx  <= '0;
      r_nlat <= '0;
      r_cnt  <= '0;
      vert1  <= '0;
      vert2  <= '0;
      vert3  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_nlat <= w_nclamp;
          r_idx  <= '0;
          r_cnt  <= '0;
        end
        S_FETCH: if (w_fetch_end) begin
          r_cnt <= '0;
          if (w_cull) r_idx <= r_idx + 1'b1;
          else begin
            vert1 <= tri_data[80:54];
            vert2 <= tri_data[53:27];
            vert3 <= tri_data[26:0];
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_HOLD: if (!w_last) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // One-deep frame queue; a start in IDLE consumes it, a coincident request re-queues.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                         r_pend <= 1'b0;
    else if (w_start)                                   r_pend <= r_pend && new_frame;
    else if (new_frame && (busy || r_state == S_DONE)) r_pend <= 1'b1;
  end

endmodule

// File: tb/tb_tri_dispatch.sv
// Self-checking bench for tri_dispatch: a monitor logs every issued triangle,
// frame_done and overrun; each task compares the log against the expected
// sequence derived from the frame rules (issue order, timing, culling).
module tb_tri_dispatch;
  localparam int MAX_TRIS = 256;
  localparam int L        = 2;
  localparam int ADDR_W   = 8;
  localparam int P        = L + 2;   // cycles per triangle with ras_ready=1

  logic              clk_in = 1'b0, rst_in = 1'b1, new_frame = 1'b0, ras_ready = 1'b0;
  logic [ADDR_W:0]   num_tris = '0;
  logic [ADDR_W-1:0] tri_addr;
  logic [80:0]       tri_data;
  logic [2:0][8:0]   vert1, vert2, vert3;
  logic              valid_tri, obj_done, busy, frame_done, overrun;

  logic [80:0] rom [MAX_TRIS];
  int cyc = 0, n_chk = 0, n_fail = 0;

  int          v_cyc[$];
  int          v_addr[$];
  logic [80:0] v_word[$];
  logic        v_od[$];
  int          fd_cyc[$];
  int          ov_cnt = 0, bad_od = 0;

  tri_dispatch #(.MAX_TRIS(MAX_TRIS), .ROM_LATENCY(L), .ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_frame(new_frame), .num_tris(num_tris),
    .tri_addr(tri_addr), .tri_data(tri_data), .ras_ready(ras_ready),
    .vert1(vert1), .vert2(vert2), .vert3(vert3), .valid_tri(valid_tri),
    .obj_done(obj_done), .busy(busy), .frame_done(frame_done), .overrun(overrun));

  always #5 clk_in = ~clk_in;

  // Synchronous ROM: data follows the address after one register stage.
  always @(posedge clk_in) begin
    cyc      <= cyc + 1;
    tri_data <= rom[tri_addr];
  end

  always @(negedge clk_in) begin
    if (valid_tri === 1'b1) begin
      v_cyc.push_back(cyc);
      v_addr.push_back(int'(tri_addr));
      v_word.push_back({vert1, vert2, vert3});
      v_od.push_back(obj_done);
    end
    if (obj_done === 1'b1 && valid_tri !== 1'b1) bad_od++;
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic clr();
    v_cyc.delete(); v_addr.delete(); v_word.delete(); v_od.delete(); fd_cyc.delete();
    ov_cnt = 0; bad_od = 0;
  endtask

  task automatic start_frame(input int n, output int s);
    num_tris  = (ADDR_W+1)'(n);
    new_frame = 1'b1;
    s = cyc;
    tick();
    new_frame = 1'b0;
  endtask

  // Front-facing triangle: right angle with legs d along +x and +y, area d*d > 0.
  function automatic logic [80:0] front_word();
    logic [8:0] x, y, d;
    x = 9'($urandom_range(0, 400));
    y = 9'($urandom_range(0, 400));
    d = 9'($urandom_range(1, 100));
    return {x, y, 9'($urandom), x + d, y, 9'($urandom), x, y + d, 9'($urandom)};
  endfunction

`ifdef BACKFACE_CULL_EN
  function automatic int area(input logic [80:0] w);
    int x1, y1, x2, y2, x3, y3;
    x1 = int'(w[80:72]); y1 = int'(w[71:63]);
    x2 = int'(w[53:45]); y2 = int'(w[44:36]);
    x3 = int'(w[26:18]); y3 = int'(w[17:9]);
    return (x2 - x1) * (y3 - y1) - (x3 - x1) * (y2 - y1);
  endfunction
`endif

  // Which triangles of an n-triangle object reach the rasterizer.
  function automatic bit keep(input logic [80:0] w, input int k, input int n);
`ifdef BACKFACE_CULL_EN
    return !(area(w) <= 0 && k != n - 1);
`else
    return (k >= 0) && (n > 0) && (w === w);
`endif
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    tick(2);
    n_chk++; if (tri_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", tri_addr); end
    n_chk++; if ({vert1, vert2, vert3} !== '0) begin n_fail++; $display("FAIL reset_verts got=%0h exp=0", {vert1, vert2, vert3}); end
    n_chk++; if ({valid_tri, obj_done, busy, frame_done, overrun} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000", {valid_tri, obj_done, busy, frame_done, overrun}); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s;
    clr();
    ras_ready = 1'b1;
    start_frame(3, s);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
    tick(3 * P + 4);
    n_chk++; if (v_cyc.size() != 3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", v_cyc.size()); end
    for (int k = 0; k < v_cyc.size() && k < 3; k++) begin
      n_chk++; if (v_cyc[k] != s + L + 1 + k * P) begin n_fail++; $display("FAIL basic_time[%0d] got=%0d exp=%0d", k, v_cyc[k], s + L + 1 + k * P); end
      n_chk++; if (v_addr[k] != k) begin n_fail++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", k, v_addr[k], k); end
      n_chk++; if (v_word[k] !== rom[k]) begin n_fail++; $display("FAIL basic_verts[%0d] got=%0h exp=%0h", k, v_word[k], rom[k]); end
      n_chk++; if (v_od[k] !== (k == 2)) begin n_fail++; $display("FAIL basic_objdone[%0d] got=%b exp=%b", k, v_od[k], k == 2); end
    end
    n_chk++; if (fd_cyc.size() != 1 || fd_cyc[0] != s + 3 * P + 1) begin
      n_fail++; $display("FAIL basic_frame_done count=%0d first=%0d exp=%0d", fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] : -1, s + 3 * P + 1); end
  endtask

  task automatic test_stall();
    int s;
    clr();
    ras_ready = 1'b0;
    start_frame(2, s);
    tick(L);                              // now in the first ISSUE cycle
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (valid_tri !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=0", i, valid_tri); end
      n_chk++; if ({vert1, vert2, vert3} !== rom[0]) begin n_fail++; $display("FAIL stall_verts[%0d] got=%0h exp=%0h", i, {vert1, vert2, vert3}, rom[0]); end
      tick();
    end
    ras_ready = 1'b1;
    #1;
    n_chk++; if (valid_tri !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", valid_tri); end
    tick(2 * L + 8);
    n_chk++; if (v_cyc.size() != 2 || v_cyc[0] != s + L + 11) begin
      n_fail++; $display("FAIL stall_seq count=%0d first=%0d exp_count=2 exp_first=%0d", v_cyc.size(), (v_cyc.size() > 0) ? v_cyc[0] : -1, s + L + 11); end
    n_chk++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL stall_frame_done got=%0d exp=1", fd_cyc.size()); end
  endtask

  task automatic test_zero();
    int s;
    clr();
    ras_ready = 1'b1;
    start_frame(0, s);
    tick(4);
    n_chk++; if (fd_cyc.size() != 1 || fd_cyc[0] != s + 1) begin
      n_fail++; $display("FAIL zero_frame_done count=%0d first=%0d exp=%0d", fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] : -1, s + 1); end
    n_chk++; if (v_cyc.size() != 0) begin n_fail++; $display("FAIL zero_valid got=%0d exp=0", v_cyc.size()); end
  endtask

  task automatic test_pending();
    int s, d, e;
    clr();
    ras_ready = 1'b1;
    start_frame(5, s);
    num_tris = (ADDR_W+1)'(2);            // size of the queued frame
    tick(3);
    new_frame = 1'b1; tick(); new_frame = 1'b0;
    tick(2);
    new_frame = 1'b1; tick(); new_frame = 1'b0;
    tick(7 * P + 8);
    d = s + 5 * P + 1;                    // first DONE cycle
    e = d + 1;                            // queued frame starts on IDLE re-entry
    n_chk++; if (v_cyc.size() != 7) begin n_fail++; $display("FAIL pend_count got=%0d exp=7", v_cyc.size()); end
    for (int k = 0; k < v_cyc.size() && k < 7; k++) begin
      int ec, ea;
      ec = (k < 5) ? s + L + 1 + k * P : e + L + 1 + (k - 5) * P;
      ea = (k < 5) ? k : k - 5;
      n_chk++; if (v_cyc[k] != ec || v_addr[k] != ea || v_od[k] !== (k == 4 || k == 6)) begin
        n_fail++; $display("FAIL pend_issue[%0d] cyc=%0d addr=%0d od=%b exp cyc=%0d addr=%0d od=%b", k, v_cyc[k], v_addr[k], v_od[k], ec, ea, k == 4 || k == 6); end
    end
    n_chk++; if (fd_cyc.size() != 2 || fd_cyc[0] != d || fd_cyc[1] != e + 2 * P + 1) begin
      n_fail++; $display("FAIL pend_frame_done count=%0d exp=2 (cycles %0d,%0d)", fd_cyc.size(), d, e + 2 * P + 1); end
    n_chk++; if (ov_cnt != 1) begin n_fail++; $display("FAIL pend_overrun got=%0d exp=1", ov_cnt); end
  endtask

  task automatic test_clamp();
    int s, ods;
    clr();
    ras_ready = 1'b1;
    start_frame(300, s);
    num_tris = '0;
    tick(MAX_TRIS * P + 6);
    ods = 0;
    foreach (v_od[k]) if (v_od[k] === 1'b1) ods++;
    n_chk++; if (v_cyc.size() != MAX_TRIS) begin n_fail++; $display("FAIL clamp_count got=%0d exp=%0d", v_cyc.size(), MAX_TRIS); end
    n_chk++; if (v_cyc.size() == MAX_TRIS && (v_addr[MAX_TRIS-1] != MAX_TRIS - 1 || v_od[MAX_TRIS-1] !== 1'b1)) begin
      n_fail++; $display("FAIL clamp_last addr=%0d od=%b exp addr=%0d od=1", v_addr[MAX_TRIS-1], v_od[MAX_TRIS-1], MAX_TRIS - 1); end
    n_chk++; if (ods != 1 || fd_cyc.size() != 1) begin n_fail++; $display("FAIL clamp_done objdone=%0d frame_done=%0d exp 1,1", ods, fd_cyc.size()); end
  endtask

  task automatic test_random();
    int s, n, cnt;
    int exp_a[$];
    for (int f = 0; f < 6; f++) begin
      clr();
      exp_a.delete();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        rom[k] = 81'({$urandom, $urandom, $urandom});
        if (keep(rom[k], k, n)) exp_a.push_back(k);
      end
      start_frame(n, s);
      cnt = 0;
      while (fd_cyc.size() == 0 && cnt < 300) begin
        ras_ready = 1'($urandom_range(0, 1));
        tick();
        cnt++;
      end
      tick();
      n_chk++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL rand%0d_frame_done got=%0d exp=1", f, fd_cyc.size()); end
      n_chk++; if (v_addr.size() != exp_a.size()) begin n_fail++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, v_addr.size(), exp_a.size()); end
      for (int k = 0; k < v_addr.size() && k < exp_a.size(); k++) begin
        n_chk++; if (v_addr[k] != exp_a[k] || v_word[k] !== rom[exp_a[k]] || v_od[k] !== (exp_a[k] == n - 1)) begin
          n_fail++; $display("FAIL rand%0d_issue[%0d] addr=%0d word=%0h od=%b exp addr=%0d word=%0h", f, k, v_addr[k], v_word[k], v_od[k], exp_a[k], rom[exp_a[k]]); end
      end
      n_chk++; if (bad_od != 0) begin n_fail++; $display("FAIL rand%0d_objdone_unqualified got=%0d exp=0", f, bad_od); end
    end
    for (int k = 0; k < MAX_TRIS; k++) rom[k] = front_word();
  endtask

  task automatic test_reset_mid();
    int s;
    clr();
    ras_ready = 1'b1;
    start_frame(3, s);
    tick(L + 1);                          // HOLD of idx 0
    ras_ready = 1'b0;
    tick(P);                              // parked in ISSUE of idx 1
    n_chk++; if (tri_addr !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre addr=%0d busy=%b exp 1,1", tri_addr, busy); end
    ras_ready = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    n_chk++; if ({valid_tri, obj_done, busy, frame_done, overrun} !== 5'b0 || tri_addr !== '0 || {vert1, vert2, vert3} !== '0) begin
      n_fail++; $display("FAIL rmid_reset flags=%b addr=%0d verts=%0h exp all zero", {valid_tri, obj_done, busy, frame_done, overrun}, tri_addr, {vert1, vert2, vert3}); end
    tick(2);
    rst_in = 1'b0;
    tick();
    clr();
    start_frame(3, s);
    tick(3 * P + 4);
    n_chk++; if (v_addr.size() != 3 || v_addr[0] != 0 || v_cyc[0] != s + L + 1) begin
      n_fail++; $display("FAIL rmid_restart count=%0d first_addr=%0d exp count=3 addr=0", v_addr.size(), (v_addr.size() > 0) ? v_addr[0] : -1); end
    n_chk++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL rmid_frame_done got=%0d exp=1", fd_cyc.size()); end
  endtask

  task automatic test_cull();
    int s;
    int exp_a[$];
    clr();
    rom[0] = front_word();
    rom[1] = {9'd10, 9'd10, 9'd0, 9'd11, 9'd15, 9'd0, 9'd11, 9'd10, 9'd0};  // area -5
    rom[2] = {9'd10, 9'd10, 9'd7, 9'd11, 9'd15, 9'd7, 9'd11, 9'd10, 9'd7};  // clockwise, last
    for (int k = 0; k < 3; k++) if (keep(rom[k], k, 3)) exp_a.push_back(k);
`ifdef BACKFACE_CULL_EN
    n_chk++; if (exp_a.size() != 2) begin n_fail++; $display("FAIL cull_model got=%0d exp=2", exp_a.size()); end
`endif
    ras_ready = 1'b1;
    start_frame(3, s);
    tick(3 * P + 6);
    n_chk++; if (v_addr.size() != exp_a.size()) begin n_fail++; $display("FAIL cull_count got=%0d exp=%0d", v_addr.size(), exp_a.size()); end
    for (int k = 0; k < v_addr.size() && k < exp_a.size(); k++) begin
      n_chk++; if (v_addr[k] != exp_a[k] || v_od[k] !== (exp_a[k] == 2) || v_word[k] !== rom[exp_a[k]]) begin
        n_fail++; $display("FAIL cull_issue[%0d] addr=%0d od=%b exp addr=%0d od=%b", k, v_addr[k], v_od[k], exp_a[k], exp_a[k] == 2); end
    end
    n_chk++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL cull_frame_done got=%0d exp=1", fd_cyc.size()); end
  endtask

  initial begin
    for (int k = 0; k < MAX_TRIS; k++) rom[k] = front_word();
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_pending();
    test_clamp();
    test_random();
    test_reset_mid();
    test_cull();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
